// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: oversampled, 3-sample majority vote, optional parity, 1-2 stop bits,
// valid/ready output with parity, framing and sticky overrun reporting.
module uart_rx_cfg #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SW-1:0] MID_M1    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] MID       = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] MID_P1    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] LAST      = SW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          SIDX_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_ARM,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SW-1:0]          scnt;
    logic [IW-1:0]          idx;
    logic                   sidx;
    logic [DATA_BITS-1:0]   shreg;
    logic [1:0]             smp_q;
    logic                   perr_q;
    logic                   ferr_q;

    logic rx_s_c;
    logic vote_c;
    logic vote_pt_c;
    logic bit_end_c;
    logic commit_c;
    logic accept_c;

    assign rx_s_c    = sync_q[SYNC_STAGES-1];
    assign vote_c    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_c) | (smp_q[1] & rx_s_c);
    assign vote_pt_c = (scnt == MID_P1);
    assign bit_end_c = (scnt == LAST);
    assign commit_c  = tick && (state == S_STOP) && vote_pt_c && (sidx == SIDX_LAST);
    assign accept_c  = valid && ready;

    // rx synchroniser, idles high
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    // Receive FSM; advances only on tick cycles
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= S_ARM;
            scnt   <= '0;
            idx    <= '0;
            sidx   <= 1'b0;
            shreg  <= '0;
            smp_q  <= '0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            busy   <= 1'b0;
        end else if (tick) begin
            if (scnt == MID_M1) smp_q[0] <= rx_s_c;
            if (scnt == MID)    smp_q[1] <= rx_s_c;
            case (state)
                S_ARM: begin
                    if (rx_s_c) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (!rx_s_c) begin
                        state  <= S_START;
                        scnt   <= '0;
                        idx    <= '0;
                        sidx   <= 1'b0;
                        shreg  <= '0;
                        perr_q <= 1'b0;
                        ferr_q <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                S_START: begin
                    scnt <= bit_end_c ? '0 : scnt + 1'b1;
                    if (vote_pt_c && vote_c) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (bit_end_c) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    scnt <= bit_end_c ? '0 : scnt + 1'b1;
                    if (vote_pt_c) shreg[idx] <= vote_c;
                    if (bit_end_c) begin
                        if (idx == IDX_LAST) begin
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    scnt <= bit_end_c ? '0 : scnt + 1'b1;
                    if (vote_pt_c) perr_q <= vote_c ^ (^shreg) ^ ODD_PAR;
                    if (bit_end_c) state <= S_STOP;
                end
                S_STOP: begin
                    scnt <= bit_end_c ? '0 : scnt + 1'b1;
                    if (vote_pt_c) ferr_q <= ferr_q | ~vote_c;
                    // Commit mid-way through the last stop bit so a prompt next start edge is caught
                    if (vote_pt_c && (sidx == SIDX_LAST)) begin
                        state <= vote_c ? S_IDLE : S_ARM;
                        scnt  <= '0;
                        busy  <= 1'b0;
                    end else if (bit_end_c) begin
                        sidx <= sidx + 1'b1;
                    end
                end
                default: begin
                    state <= S_ARM;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register and handshake
    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (commit_c) begin
            if (!valid || ready) begin
                data_out   <= shreg;
                parity_err <= perr_q;
                frame_err  <= ferr_q | ~vote_c;
                valid      <= 1'b1;
                if (accept_c) overrun <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (accept_c) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule
